// File: rtl/clk_div_checker_if.sv
// Bundle of divided clocks under test and the checker's status outputs.
// master: the side driving the divided clocks (generator / bench).
// slave:  the checker, which samples the clocks and reports status.
interface clk_div_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clkf;
  logic             clk2f;
  logic             clk4f;
  logic             locked;
  logic             err;
  logic [2:0]       err_code;
  logic             sync_to;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;

  modport master (
    output clkf, clk2f, clk4f,
    input  locked, err, err_code, sync_to, err_sticky, err_count
  );

  modport slave (
    input  clkf, clk2f, clk4f,
    output locked, err, err_code, sync_to, err_sticky, err_count
  );
endinterface

// File: rtl/clk_div_checker.sv
// Receive-side monitor for a clock divider: checks that clkf/clk2f/clk4f are
// the /8, /4, /2 divisions of clk8f, phase-aligned to the rising edge of clkf.
// Reports lock, per-clock mismatch masks, sync timeouts and an error count.
module clk_div_checker #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned LOCK_PERIODS = 2,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input logic              clk8f,
  input logic              reset,
  clk_div_checker_if.slave bus
);

  localparam int unsigned GW = (LOCK_PERIODS > 1) ? $clog2(LOCK_PERIODS + 1) : 1;
  localparam int unsigned TW = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    StSync,
    StCheck,
    StLocked
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ph_q, ph_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             clkf_q;

  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             sync_to_q, sync_to_d;
  logic             err_sticky_q;
  logic [CNT_W-1:0] err_count_q;

  logic [2:0]       sample;
  logic [2:0]       mism;
  logic             sync_edge;

  // Sample packed as {clkf, clk2f, clk4f}; at phase p the expected pattern is ~p.
  assign sample    = {bus.clkf, bus.clk2f, bus.clk4f};
  assign mism      = sample ^ ~ph_q;
  assign sync_edge = bus.clkf & ~clkf_q & bus.clk2f & bus.clk4f;

  // Next-state and next-output decode for the sync/check/lock sequence.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    good_cnt_d = good_cnt_q;
    to_cnt_d   = to_cnt_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    err_code_d = 3'b000;
    sync_to_d  = 1'b0;
    unique case (state_q)
      StSync: begin
        if (sync_edge) begin
          // The sync edge itself is phase 0, so checking resumes at phase 1.
          state_d    = StCheck;
          ph_d       = 3'd1;
          good_cnt_d = '0;
          to_cnt_d   = '0;
        end else if (to_cnt_q == TW'(SYNC_TIMEOUT - 1)) begin
          err_d     = 1'b1;
          sync_to_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      StCheck, StLocked: begin
        if (mism != 3'b000) begin
          err_d      = 1'b1;
          err_code_d = mism;
          locked_d   = 1'b0;
          state_d    = StSync;
          ph_d       = 3'd0;
          good_cnt_d = '0;
          to_cnt_d   = '0;
        end else begin
          ph_d = ph_q + 3'd1;
          if (state_q == StCheck && ph_q == 3'd7) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_q == GW'(LOCK_PERIODS - 1)) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StSync;
      end
    endcase
  end

  // Control state and registered outputs; err_* track the same-edge error decision.
  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      state_q      <= StSync;
      ph_q         <= 3'd0;
      good_cnt_q   <= '0;
      to_cnt_q     <= '0;
      clkf_q       <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 3'b000;
      sync_to_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      good_cnt_q   <= good_cnt_d;
      to_cnt_q     <= to_cnt_d;
      clkf_q       <= bus.clkf;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      sync_to_q    <= sync_to_d;
      err_sticky_q <= err_sticky_q | err_d;
      if (err_d && err_count_q != '1) begin
        err_count_q <= err_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.sync_to    = sync_to_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// Randomized scoreboard bench for clk_div_checker. A cycle-indexed reference
// model predicts error events (queued) and lock/count/sticky status; a monitor
// process compares the DUT after every clock edge.
module tb_clk_div_checker;

  localparam int LOCK_PERIODS = 2;
  localparam int SYNC_TIMEOUT = 32;

  logic clk8f = 1'b0;
  logic reset = 1'b1;

  clk_div_checker_if #(.CNT_W(8)) bus ();

  clk_div_checker #(
    .CNT_W       (8),
    .LOCK_PERIODS(LOCK_PERIODS),
    .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) dut (
    .clk8f(clk8f),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk8f = ~clk8f;

  typedef struct {
    logic [2:0] code;
    logic       sto;
  } ev_t;

  ev_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state, expressed as cycle indices rather than counters.
  int   m_n       = 0;  // index of the next sampled edge
  bit   m_trk     = 0;  // tracking a verified pattern
  int   m_t0      = 0;  // edge index of the accepted sync edge
  int   m_idle0   = 0;  // first edge index of the current sync search
  bit   m_prev_f  = 0;  // clkf seen at the previous sampled edge
  bit   m_locked  = 0;
  int   m_pulses  = 0;

  int g = 0;  // generator phase

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ideal(input int p);
    return 3'(7 - (p % 8));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_trk    = 0;
    m_idle0  = m_n;
    m_prev_f = 0;
    m_locked = 0;
    m_pulses = 0;
  endtask

  // Predict the effect of the upcoming edge sampling s = {clkf, clk2f, clk4f}.
  task automatic model(input logic [2:0] s);
    ev_t e;
    if (m_trk) begin
      logic [2:0] want;
      want = 3'(7 - ((m_n - m_t0) % 8));
      if (s != want) begin
        e.code = s ^ want;
        e.sto  = 1'b0;
        exp_q.push_back(e);
        m_pulses++;
        m_trk    = 0;
        m_locked = 0;
        m_idle0  = m_n + 1;
      end else begin
        m_locked = ((m_n - m_t0 + 1) / 8) >= LOCK_PERIODS;
      end
    end else if (s == 3'b111 && !m_prev_f) begin
      m_trk = 1;
      m_t0  = m_n;
    end else if ((m_n - m_idle0) % SYNC_TIMEOUT == SYNC_TIMEOUT - 1) begin
      e.code = 3'b000;
      e.sto  = 1'b1;
      exp_q.push_back(e);
      m_pulses++;
    end
    m_prev_f = s[2];
    m_n++;
  endtask

  task automatic step(input logic [2:0] s);
    @(negedge clk8f);
    bus.clkf  = s[2];
    bus.clk2f = s[1];
    bus.clk4f = s[0];
    model(s);
    @(posedge clk8f);
  endtask

  task automatic run_ideal(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(ideal(g));
      g++;
    end
  endtask

  // Advance the ideal stream until the model says locked and phase ph is next.
  task automatic seek_locked(input int ph);
    int k = 0;
    while (!(m_locked && (g % 8) == ph) && k < 200) begin
      step(ideal(g));
      g++;
      k++;
    end
    chk("seek_locked", int'(m_locked && (g % 8) == ph), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_err_code"}, int'(bus.err_code), 0);
    chk({tag, "_sync_to"}, int'(bus.sync_to), 0);
    chk({tag, "_err_sticky"}, int'(bus.err_sticky), 0);
    chk({tag, "_err_count"}, int'(bus.err_count), 0);
  endtask

  // Monitor: pop the predicted event for each edge and compare all outputs.
  always @(posedge clk8f) begin
    ev_t e;
    int  cnt_exp;
    #1;
    if (!reset) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("err", int'(bus.err), 1);
        chk("err_code", int'(bus.err_code), int'(e.code));
        chk("sync_to", int'(bus.sync_to), int'(e.sto));
      end else begin
        chk("err_idle", int'(bus.err), 0);
        chk("sync_to_idle", int'(bus.sync_to), 0);
      end
      cnt_exp = (m_pulses > 255) ? 255 : m_pulses;
      chk("locked", int'(bus.locked), int'(m_locked));
      chk("err_count", int'(bus.err_count), cnt_exp);
      chk("err_sticky", int'(bus.err_sticky), int'(m_pulses > 0));
    end
  end

  initial begin
    bus.clkf  = 1'b0;
    bus.clk2f = 1'b0;
    bus.clk4f = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk8f);
    #2;
    reset = 1'b0;
    model_reset();

    // Ideal generator from a random starting phase after a short idle.
    repeat ($urandom_range(0, 7)) step(3'b000);
    g = $urandom_range(0, 7);
    run_ideal(1000);

    // Single-cycle clk2f inversion at phase 3 while locked, then relock.
    seek_locked(3);
    step(ideal(g) ^ 3'b010);
    g++;
    run_ideal(40);

    // clkf and clk4f flipped together while locked.
    seek_locked($urandom_range(0, 7));
    step(ideal(g) ^ 3'b101);
    g++;
    run_ideal(40);

    // Sparse random glitches on any combination of the three clocks.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] s;
      s = ideal(g);
      if ($urandom_range(0, 31) == 0) s = s ^ 3'($urandom_range(1, 7));
      step(s);
      g++;
    end

    // clkf lagging clk2f/clk4f by one clk8f cycle: only timeouts expected.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] a;
      logic [2:0] b;
      a = ideal(g);
      b = ideal(g + 7);
      step({b[2], a[1:0]});
      g++;
    end
    run_ideal(40);

    // Asynchronous reset between edges while locked.
    seek_locked($urandom_range(0, 7));
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk8f);
    #2;
    reset = 1'b0;
    model_reset();
    run_ideal(40);
    chk("relock_after_reset", int'(bus.locked), 1);

    // All inputs stuck low: timeouts every SYNC_TIMEOUT cycles until saturation.
    for (int i = 0; i < 255 * SYNC_TIMEOUT + 100; i++) step(3'b000);
    chk("err_count_saturated", int'(bus.err_count), 255);
    chk("queue_drained", exp_q.size(), 0);

    @(negedge clk8f);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
